// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM state encoding and the GF(2^8) /
// state-transform helpers used by both the encrypt and decrypt cores.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SUB   = 3'd3,
        ST_ADD   = 3'd4,
        ST_MIX   = 3'd5,
        ST_DONE  = 3'd6
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ gm2(x);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gm2(aa);
        end
        return p;
    endfunction

    // Byte (row r, column c) lives at bits [127-32c-8r -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-32*c-8*row -: 8] = s[127-32*((c-row+4)%4)-8*row -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3);
            r[119-32*c -: 8] = gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3);
            r[111-32*c -: 8] = gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3);
            r[103-32*c -: 8] = gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] addroundkey(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// 32-bit inverse S-box: four parallel byte lookups, each the inverse affine
// map followed by the multiplicative inverse (x^254) in GF(2^8).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] t;
        logic [7:0] acc;
        b   = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
        t   = gf_mul(b, b);
        acc = t;
        for (int i = 0; i < 6; i++) begin
            t   = gf_mul(t, t);
            acc = gf_mul(acc, t);
        end
        return acc;
    endfunction

    assign word_out = {inv_sbox_byte(word_in[31:24]), inv_sbox_byte(word_in[23:16]),
                       inv_sbox_byte(word_in[15:8]),  inv_sbox_byte(word_in[7:0])};

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: one shared 32-bit inverse S-box, one column
// per cycle, round keys requested from the key generator from 10 down to 0.
module aes_decryption #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS  // only 10 is legal
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         next,
    input  logic         key_ready,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] input_block,
    output logic [127:0] output_block,
    output logic         block_ready,
    output logic         busy
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_state_e   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_q, out_d;
    logic         ready_q, ready_d;

    logic [6:0]   col_base;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;

    // Column k occupies bits [127-32k -: 32].
    assign col_base = 7'd127 - {col_q, 5'd0};
    assign sbox_in  = data_q[col_base -: 32];

    aes_inv_sbox u_inv_sbox (
        .word_in  (sbox_in),
        .word_out (sbox_out)
    );

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        data_d  = data_q;
        out_d   = out_q;
        ready_d = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (next && key_ready) begin
                    state_d = ST_INIT;
                    ready_d = 1'b0;
                end
            end
            ST_INIT: begin
                data_d  = addroundkey(input_block, round_key);
                round_d = LAST_ROUND - 4'd1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                data_d  = inv_shiftrows(data_q);
                col_d   = 2'd0;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                data_d[col_base -: 32] = sbox_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = ST_ADD;
            end
            ST_ADD: begin
                data_d = addroundkey(data_q, round_key);
                // The last round skips InvMixColumns; round stops at 0 instead of wrapping.
                if (round_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q - 4'd1;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                data_d  = inv_mixcolumns(data_q);
                state_d = ST_SHIFT;
            end
            ST_DONE: begin
                out_d   = data_q;
                ready_d = 1'b1;
                round_d = LAST_ROUND;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) begin
            state_q <= ST_IDLE;
            round_q <= LAST_ROUND;
            col_q   <= 2'd0;
            data_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            col_q   <= col_d;
            data_q  <= data_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign round        = round_q;
    assign output_block = out_q;
    assign block_ready  = ready_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption: FIPS known answers, control corner
// cases and random round trips against a byte-level AES encrypt/key model.
module tb_aes_decryption;

    logic         aclk;
    logic         aresetn;
    logic         next;
    logic         key_ready;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] input_block;
    logic [127:0] output_block;
    logic         block_ready;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_tbl [16];

    aes_decryption dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .next         (next),
        .key_ready    (key_ready),
        .round        (round),
        .round_key    (round_key),
        .input_block  (input_block),
        .output_block (output_block),
        .block_ready  (block_ready),
        .busy         (busy)
    );

    assign round_key = rk_tbl[round];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tbl[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Forward cipher with the currently loaded key; byte i = row i%4, column i/4.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] blk;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        blk = pt ^ rk_tbl[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbox_t[s[4*((c+row)%4)+row]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
                    t[4*c+3] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
            blk = blk ^ rk_tbl[r];
        end
        return blk;
    endfunction

    // ---------------- stimulus ----------------
    // Pulses next, waits (bounded) for block_ready and checks latency, result,
    // handshake flags, output hold and optionally the round-index trace.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt, input int poke_at, input bit do_trace);
        logic [127:0] out_before;
        int           lat;
        int           trace [$];
        load_key(key);
        out_before = output_block;
        lat = -1;
        @(negedge aclk);
        input_block = ct;
        next        = 1'b1;
        @(posedge aclk);
        #1;
        next = 1'b0;
        check({tag, " busy_at_accept"}, 128'(busy), 128'd1);
        check({tag, " ready_drop"}, 128'(block_ready), 128'd0);
        trace.push_back(int'(round));
        for (int cyc = 1; cyc <= 200; cyc++) begin
            next = (cyc == poke_at);
            @(posedge aclk);
            #1;
            if (int'(round) != trace[$]) trace.push_back(int'(round));
            if (cyc == 70) check({tag, " out_held"}, output_block, out_before);
            if (block_ready) begin
                lat = cyc;
                break;
            end
        end
        next = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'd71);
        check({tag, " plaintext"}, output_block, pt);
        check({tag, " idle_after"}, 128'(busy), 128'd0);
        if (do_trace) begin
            check({tag, " trace_len"}, 128'(trace.size()), 128'd12);
            for (int i = 0; i < trace.size() && i < 12; i++)
                check($sformatf("%s trace[%0d]", tag, i), 128'(trace[i]), 128'((i == 11) ? 10 : 10 - i));
        end
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] key, pt;
        bit           quiet;
        aresetn     = 1'b0;
        next        = 1'b0;
        key_ready   = 1'b1;
        input_block = '0;
        for (int r = 0; r < 16; r++) rk_tbl[r] = '0;
        build_sbox();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("reset round", 128'(round), 128'd10);
        check("reset ready", 128'(block_ready), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset out", output_block, 128'd0);

        run_block("fips_b", KEY_B, CT_B, PT_B, 0, 1'b0);
        // Back-to-back: next lands on the first IDLE cycle; first result held until second DONE.
        run_block("fips_c", KEY_C, CT_C, PT_C, 0, 1'b1);

        // key_ready low while next is high in IDLE: nothing starts.
        @(negedge aclk);
        key_ready = 1'b0;
        next      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            #1;
            check("nokey busy", 128'(busy), 128'd0);
            check("nokey ready", 128'(block_ready), 128'd1);
        end
        @(negedge aclk);
        next      = 1'b0;
        key_ready = 1'b1;
        run_block("poke20", KEY_B, CT_B, PT_B, 20, 1'b0);

        // Reset pulse mid-block aborts it.
        load_key(KEY_C);
        @(negedge aclk);
        input_block = CT_C;
        next        = 1'b1;
        @(posedge aclk);
        #1;
        next = 1'b0;
        repeat (34) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("abort ready", 128'(block_ready), 128'd0);
        check("abort out", output_block, 128'd0);
        check("abort round", 128'(round), 128'd10);
        check("abort busy", 128'(busy), 128'd0);
        quiet = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge aclk);
            #1;
            if (block_ready || busy) quiet = 1'b0;
        end
        check("abort quiet", 128'(quiet), 128'd1);
        run_block("after_reset", KEY_C, CT_C, PT_C, 0, 1'b0);

        // Random round trips through the reference encryptor.
        for (int n = 0; n < 150; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_key(key);
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            run_block($sformatf("rand%0d", n), key, encrypt(pt), pt, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
